// File: rtl/mouse_packet_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_packet_decoder_pkg
// Description : PS/2 mouse protocol constants, screen size, packet FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_packet_decoder_pkg;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_DEV_ID = 8'h00;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2
   } pkt_state_t;

   // Overflow saturates to the extreme of the direction given by the sign bit.
   function automatic logic [8:0] decode_motion(input logic sign_bit,
                                                input logic ovf,
                                                input logic [7:0] mag);
      if (ovf)
         return sign_bit ? 9'h100 : 9'h0FF;
      return {sign_bit, mag};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mouse_packet_decoder_cursor_axis.sv
`default_nettype none
// ============================================================================
// Module      : cursor_axis
// Description : One cursor coordinate; adds (or subtracts) a scaled signed
//               motion delta on each load and clamps to [0, MAX].
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_axis #(
   parameter int W      = 8,
   parameter int MAX    = 159,
   parameter int INIT   = 80,
   parameter int SHIFT  = 1,
   parameter bit INVERT = 1'b0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic signed [8:0] i_delta,
   output logic [W-1:0]      o_pos
);

   localparam logic signed [10:0] c_MAX      = 11'(MAX);
   localparam logic [W-1:0]       c_MAX_POS  = W'(MAX);
   localparam logic [W-1:0]       c_INIT_POS = W'(INIT);

   logic [W-1:0]       r_pos;
   logic [W-1:0]       w_next;
   logic signed [10:0] w_pos_ext;
   logic signed [10:0] w_step;
   logic signed [10:0] w_sum;

   always_comb begin
      w_pos_ext = $signed({{(11 - W){1'b0}}, r_pos});
      w_step    = $signed({{2{i_delta[8]}}, i_delta}) >>> SHIFT;
      w_sum     = INVERT ? (w_pos_ext - w_step) : (w_pos_ext + w_step);
      w_next    = w_sum[W-1:0];
      if (w_sum < 11'sd0)
         w_next = '0;
      else if (w_sum > c_MAX)
         w_next = c_MAX_POS;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_pos <= c_INIT_POS;
      else if (i_load)
         r_pos <= w_next;
   end

   assign o_pos = r_pos;

endmodule
`default_nettype wire

// File: rtl/mouse_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mouse_packet_decoder
// Description : Assembles 3-byte PS/2 mouse packets, decodes buttons/motion
//               and tracks a clamped on-screen cursor position.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_packet_decoder
   import mouse_packet_decoder_pkg::*;
#(
   parameter int X_MAX          = SCREEN_W - 1,
   parameter int Y_MAX          = SCREEN_H - 1,
   parameter int X_INIT         = 80,
   parameter int Y_INIT         = 60,
   parameter int MOTION_SHIFT   = 1,
   parameter int TIMEOUT_CYCLES = 1000000
)(
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic       pkt_valid,
   output logic [2:0] buttons,
   output logic [8:0] dx,
   output logic [8:0] dy,
   output logic [7:0] cursor_x,
   output logic [6:0] cursor_y,
   output logic       sync_err
);

   localparam int                c_CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   pkt_state_t         r_state;
   pkt_state_t         w_state_next;
   logic [3:0]         r_b0_flags;     // byte0[7:4]: Y ovf, X ovf, Y sign, X sign
   logic [2:0]         r_b0_btn;
   logic [7:0]         r_b1;
   logic               r_after_bat;
   logic               w_after_bat_next;
   logic [c_CNT_W-1:0] r_idle_cnt;
   logic               w_latch_b0;
   logic               w_latch_b1;
   logic               w_pkt_done;
   logic               w_bad_byte;
   logic               w_timeout;
   logic               w_expired;
   logic [8:0]         w_dx;
   logic [8:0]         w_dy;

   assign w_expired = (r_idle_cnt == c_CNT_LAST);

   always_ff @(posedge CLOCK_50) begin
      if (reset)
         r_state <= WAIT_B0;
      else
         r_state <= w_state_next;
   end

   // A strobe always takes priority over an expiring idle timer.
   always_comb begin
      w_state_next     = r_state;
      w_after_bat_next = r_after_bat;
      w_latch_b0       = 1'b0;
      w_latch_b1       = 1'b0;
      w_pkt_done       = 1'b0;
      w_bad_byte       = 1'b0;
      w_timeout        = 1'b0;
      case (r_state)
         WAIT_B0: begin
            if (received_data_en) begin
               w_after_bat_next = (received_data == PS2_BAT_OK);
               if ((received_data != PS2_ACK) && (received_data != PS2_BAT_OK) &&
                   !((received_data == PS2_DEV_ID) && r_after_bat)) begin
                  if (!received_data[3]) begin
                     w_bad_byte = 1'b1;
                  end else begin
                     w_latch_b0   = 1'b1;
                     w_state_next = WAIT_B1;
                  end
               end
            end
         end
         WAIT_B1: begin
            if (received_data_en) begin
               w_latch_b1   = 1'b1;
               w_state_next = WAIT_B2;
            end else if (w_expired) begin
               w_timeout    = 1'b1;
               w_state_next = WAIT_B0;
            end
         end
         WAIT_B2: begin
            if (received_data_en) begin
               w_pkt_done   = 1'b1;
               w_state_next = WAIT_B0;
            end else if (w_expired) begin
               w_timeout    = 1'b1;
               w_state_next = WAIT_B0;
            end
         end
         default: w_state_next = WAIT_B0;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset || received_data_en || w_timeout || (r_state == WAIT_B0))
         r_idle_cnt <= '0;
      else
         r_idle_cnt <= r_idle_cnt + c_CNT_W'(1);
   end

   assign w_dx = decode_motion(r_b0_flags[0], r_b0_flags[2], r_b1);
   assign w_dy = decode_motion(r_b0_flags[1], r_b0_flags[3], received_data);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pkt_valid   <= 1'b0;
         sync_err    <= 1'b0;
         buttons     <= '0;
         dx          <= '0;
         dy          <= '0;
         r_after_bat <= 1'b0;
         r_b0_flags  <= '0;
         r_b0_btn    <= '0;
         r_b1        <= '0;
      end else begin
         pkt_valid   <= w_pkt_done;
         sync_err    <= w_bad_byte | w_timeout;
         r_after_bat <= w_after_bat_next;
         if (w_latch_b0) begin
            r_b0_flags <= received_data[7:4];
            r_b0_btn   <= received_data[2:0];
         end
         if (w_latch_b1)
            r_b1 <= received_data;
         if (w_pkt_done) begin
            buttons <= r_b0_btn;
            dx      <= w_dx;
            dy      <= w_dy;
         end
      end
   end

   cursor_axis #(
      .W      (8),
      .MAX    (X_MAX),
      .INIT   (X_INIT),
      .SHIFT  (MOTION_SHIFT),
      .INVERT (1'b0)
   ) u_axis_x (
      .clk     (CLOCK_50),
      .rst     (reset),
      .i_load  (w_pkt_done),
      .i_delta (w_dx),
      .o_pos   (cursor_x)
   );

   // Screen Y grows downward while PS/2 motion is positive upward.
   cursor_axis #(
      .W      (7),
      .MAX    (Y_MAX),
      .INIT   (Y_INIT),
      .SHIFT  (MOTION_SHIFT),
      .INVERT (1'b1)
   ) u_axis_y (
      .clk     (CLOCK_50),
      .rst     (reset),
      .i_load  (w_pkt_done),
      .i_delta (w_dy),
      .o_pos   (cursor_y)
   );

endmodule
`default_nettype wire

// File: tb/tb_mouse_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_packet_decoder
// Description : Randomised and directed bench for mouse_packet_decoder with a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_packet_decoder;

   localparam int c_TO    = 100;
   localparam int c_SHIFT = 1;
   localparam int c_XMAX  = 159;
   localparam int c_YMAX  = 119;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic [7:0] received_data;
   logic       received_data_en;
   logic       pkt_valid;
   logic [2:0] buttons;
   logic [8:0] dx;
   logic [8:0] dy;
   logic [7:0] cursor_x;
   logic [6:0] cursor_y;
   logic       sync_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_se     = 0;
   int n_pv     = 0;

   // reference model state
   logic [7:0] m_q[$];
   bit         m_bat;
   int         m_idle;
   int         m_cx, m_cy;
   logic [8:0] m_dx, m_dy;
   logic [2:0] m_btn;
   bit         m_pv, m_se;

   mouse_packet_decoder #(
      .TIMEOUT_CYCLES (c_TO)
   ) dut (
      .CLOCK_50         (CLOCK_50),
      .reset            (reset),
      .received_data    (received_data),
      .received_data_en (received_data_en),
      .pkt_valid        (pkt_valid),
      .buttons          (buttons),
      .dx               (dx),
      .dy               (dy),
      .cursor_x         (cursor_x),
      .cursor_y         (cursor_y),
      .sync_err         (sync_err)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int floor_div(input int a, input int d);
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   function automatic int clamp(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Computes the expected result of one clock edge from the inputs it samples.
   task automatic model_cycle(input bit en, input logic [7:0] d);
      int mx, my;
      m_pv = 0;
      m_se = 0;
      if (reset) begin
         m_q.delete();
         m_bat = 0; m_idle = 0; m_cx = 80; m_cy = 60;
         m_dx = '0; m_dy = '0; m_btn = '0;
         return;
      end
      if (!en) begin
         if (m_q.size() > 0) begin
            m_idle++;
            if (m_idle >= c_TO) begin
               m_se = 1;
               m_q.delete();
               m_idle = 0;
            end
         end
         return;
      end
      m_idle = 0;
      if (m_q.size() == 0) begin
         if (d == 8'hFA)              m_bat = 0;
         else if (d == 8'hAA)         m_bat = 1;
         else if (d == 8'h00 && m_bat) m_bat = 0;
         else begin
            m_bat = 0;
            if (!d[3]) m_se = 1;
            else       m_q.push_back(d);
         end
      end else begin
         m_q.push_back(d);
         if (m_q.size() == 3) begin
            mx = m_q[0][6] ? (m_q[0][4] ? -256 : 255) : (m_q[0][4] ? int'(m_q[1]) - 256 : int'(m_q[1]));
            my = m_q[0][7] ? (m_q[0][5] ? -256 : 255) : (m_q[0][5] ? int'(m_q[2]) - 256 : int'(m_q[2]));
            m_dx  = mx[8:0];
            m_dy  = my[8:0];
            m_btn = m_q[0][2:0];
            m_cx  = clamp(m_cx + floor_div(mx, 1 << c_SHIFT), c_XMAX);
            m_cy  = clamp(m_cy - floor_div(my, 1 << c_SHIFT), c_YMAX);
            m_pv  = 1;
            m_q.delete();
         end
      end
   endtask

   task automatic step(input bit en, input logic [7:0] d);
      received_data_en = en;
      received_data    = d;
      model_cycle(en, d);
      @(posedge CLOCK_50);
      #1;
      if (pkt_valid === 1'b1) n_pv++;
      if (sync_err === 1'b1)  n_se++;
      check_value("pkt_valid", pkt_valid, m_pv);
      check_value("sync_err", sync_err, m_se);
      check_value("buttons", buttons, m_btn);
      check_value("dx", dx, m_dx);
      check_value("dy", dy, m_dy);
      check_value("cursor_x", cursor_x, m_cx);
      check_value("cursor_y", cursor_y, m_cy);
   endtask

   task automatic send(input logic [7:0] d, input int gap);
      for (int i = 0; i < gap; i++) step(1'b0, 8'h00);
      step(1'b1, d);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int i = 0; i < cycles; i++) step(1'b0, 8'h00);
      reset = 1'b0;
   endtask

   initial begin
      int r, gap;
      logic [7:0] b;
      reset            = 1'b1;
      received_data    = 8'h00;
      received_data_en = 1'b0;

      do_reset(3);
      step(1'b0, 8'h00);
      check_value("rst_cursor_x", cursor_x, 80);
      check_value("rst_cursor_y", cursor_y, 60);

      send(8'h08, 0); send(8'h05, 0); send(8'h03, 0);
      check_value("p1_cursor_x", cursor_x, 82);
      check_value("p1_cursor_y", cursor_y, 59);

      do_reset(1);
      send(8'h19, 1); send(8'hFB, 0); send(8'h00, 2);
      check_value("p2_dx", dx, 9'h1FB);
      check_value("p2_cursor_x", cursor_x, 77);

      do_reset(1);
      send(8'h08, 0); send(8'h7F, 0); send(8'h00, 0);
      check_value("clamp_x_mid", cursor_x, 143);
      send(8'h08, 0); send(8'h7F, 0); send(8'h00, 0);
      check_value("clamp_x_max", cursor_x, 159);
      send(8'h28, 0); send(8'h00, 0); send(8'h80, 0);
      check_value("clamp_dy", dy, 9'h180);
      check_value("clamp_y_max", cursor_y, 119);

      do_reset(1);
      n_se = 0; n_pv = 0;
      send(8'hAA, 0); send(8'h00, 0); send(8'hFA, 0); send(8'h00, 0);
      send(8'h0A, 0); send(8'h01, 0); send(8'h01, 0);
      step(1'b0, 8'h00);
      check_value("bat_sync_errs", n_se, 1);
      check_value("bat_pkts", n_pv, 1);
      check_value("bat_buttons", buttons, 3'b010);

      do_reset(1);
      n_se = 0; n_pv = 0;
      send(8'h08, 0); send(8'h05, 0);
      for (int i = 0; i < c_TO; i++) step(1'b0, 8'h00);
      check_value("to_sync_errs", n_se, 1);
      check_value("to_pkts", n_pv, 0);
      send(8'h08, 0); send(8'h02, 0); send(8'h00, 0);
      check_value("to_cursor_x", cursor_x, 81);
      send(8'h48, 0); send(8'h10, 0); send(8'h00, 0);
      check_value("ovf_dx", dx, 9'h0FF);
      check_value("ovf_cursor_x", cursor_x, 159);

      n_se = 0; n_pv = 0;
      send(8'h08, 0); send(8'h05, c_TO - 1); send(8'h00, c_TO - 1);
      check_value("edge_sync_errs", n_se, 0);
      check_value("edge_pkts", n_pv, 1);

      send(8'h18, 0); send(8'h05, 1);
      do_reset(2);
      send(8'h03, 0);
      send(8'h09, 0); send(8'h04, 0); send(8'h02, 0);

      for (int k = 0; k < 1500; k++) begin
         r = $urandom_range(0, 19);
         if (r == 0)      b = 8'hAA;
         else if (r == 1) b = 8'hFA;
         else if (r == 2) b = 8'h00;
         else begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) != 0) b[3] = 1'b1;
         end
         r = $urandom_range(0, 39);
         if (r == 0)      gap = c_TO - 1;
         else if (r == 1) gap = c_TO;
         else if (r == 2) gap = c_TO + 20;
         else             gap = $urandom_range(0, 2);
         if ($urandom_range(0, 199) == 0) do_reset(2);
         send(b, gap);
      end
      step(1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
